ssrv_imem_wb_bridge: RTL and testbench



---
 rtl/ssrv_imem_wb_bridge.sv | 163 ++++++++++++++++
 tb/tb_ssrv_imem_wb_bridge.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssrv_imem_wb_bridge.sv
// Instruction-fetch bridge: one 128-bit imem fetch becomes WORDS_PER_FETCH
// single-word Wishbone reads, assembled and returned with a one-cycle response.
module ssrv_imem_wb_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORDS_PER_FETCH = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_req,
  input  logic [ADDR_WIDTH-1:0]         imem_addr,
  output logic [32*WORDS_PER_FETCH-1:0] imem_rdata,
  output logic                          imem_resp,
  output logic                          imem_err,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [3:0]                    wb_sel,
  output logic [ADDR_WIDTH-1:0]         wb_addr,
  input  logic [31:0]                   wb_data_in,
  input  logic                          wb_ack
);

  localparam int DW = 32 * WORDS_PER_FETCH;
  localparam int BW = (WORDS_PER_FETCH > 1) ? $clog2(WORDS_PER_FETCH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_FETCH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    abort_q, abort_d;
  logic                    tmo_hit_q, tmo_hit_d;
  logic [DW-1:0]           words_q, words_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    resp_q, resp_d;
  logic                    err_q, err_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    abort_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      tmo_q     <= '0;
      abort_q   <= 1'b0;
      tmo_hit_q <= 1'b0;
      words_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
      abort_q   <= abort_d;
      tmo_hit_q <= tmo_hit_d;
      words_q   <= words_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    abort_d   = abort_q;
    tmo_hit_d = tmo_hit_q;
    words_d   = words_q;
    rdata_d   = rdata_q;
    resp_d    = 1'b0;
    err_d     = 1'b0;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    addr_d    = addr_q;
    abort_now = abort_q | ~imem_req;

    case (state_q)
      IDLE: begin
        if (imem_req) begin
          state_d   = REQ;
          beat_d    = '0;
          tmo_d     = '0;
          abort_d   = 1'b0;
          tmo_hit_d = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          addr_d    = imem_addr & ~ADDR_WIDTH'(3);
        end
      end
      REQ: begin
        abort_d = abort_now;
        // Ack is checked before the timeout so a last-moment ack still completes the beat.
        if (wb_ack) begin
          words_d[{beat_q, 5'b0} +: 32] = wb_data_in;
          stb_d = 1'b0;
          if (abort_now) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end else if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            cyc_d   = 1'b0;
          end else begin
            state_d = GAP;
          end
        end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) begin
          stb_d = 1'b0;
          cyc_d = 1'b0;
          if (abort_now) begin
            state_d = IDLE;
          end else begin
            state_d   = DONE;
            tmo_hit_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        if (abort_now) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else begin
          state_d = REQ;
          stb_d   = 1'b1;
          beat_d  = beat_q + 1'b1;
          tmo_d   = '0;
          addr_d  = addr_q + ADDR_WIDTH'(4);
        end
      end
      DONE: begin
        state_d = IDLE;
        resp_d  = 1'b1;
        err_d   = tmo_hit_q;
        rdata_d = tmo_hit_q ? '0 : words_q;
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_rdata = rdata_q;
  assign imem_resp  = resp_q;
  assign imem_err   = err_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = stb_q;
  assign wb_addr    = addr_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'hF;

endmodule

// File: tb/tb_ssrv_imem_wb_bridge.sv
// Directed bench for ssrv_imem_wb_bridge: a scripted Wishbone slave returns
// 0xA0000000+addr, and each task checks one scenario cycle by cycle.
module tb_ssrv_imem_wb_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [127:0] imem_rdata;
  logic         imem_resp;
  logic         imem_err;
  logic         wb_cyc;
  logic         wb_stb;
  logic         wb_we;
  logic [3:0]   wb_sel;
  logic [31:0]  wb_addr;
  logic [31:0]  wb_data_in;
  logic         wb_ack;

  logic         no_ack;
  logic [31:0]  wait_addr;
  int unsigned  wait_n;
  int unsigned  wcnt;

  int n_vec;
  int n_err;

  ssrv_imem_wb_bridge #(
    .ADDR_WIDTH      (32),
    .WORDS_PER_FETCH (4),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .imem_err   (imem_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_addr    (wb_addr),
    .wb_data_in (wb_data_in),
    .wb_ack     (wb_ack)
  );

  always #5 clk = ~clk;

  // Slave: acks in the first strobe cycle, or after wait_n stall cycles on wait_addr.
  always @(negedge clk) begin
    if (wb_stb && !no_ack) begin
      if (wcnt >= ((wb_addr == wait_addr) ? wait_n : 0)) begin
        wb_ack     = 1'b1;
        wb_data_in = 32'hA000_0000 + wb_addr;
        wcnt       = 0;
      end else begin
        wb_ack = 1'b0;
        wcnt   = wcnt + 1;
      end
    end else begin
      wb_ack = 1'b0;
      wcnt   = 0;
    end
  end

  // Stimulus/collection only: issues a fetch at cycle 0 and reports what it saw.
  task automatic run_fetch(input logic [31:0] a, output logic [3:0][31:0] addrs,
                           output int nbeats, output logic [127:0] data,
                           output logic err, output int resp_cycle);
    logic prev;
    @(negedge clk);
    imem_req   = 1'b1;
    imem_addr  = a;
    nbeats     = 0;
    prev       = 1'b0;
    resp_cycle = -1;
    data       = '0;
    err        = 1'b0;
    addrs      = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (wb_stb && !prev && nbeats < 4) begin
        addrs[nbeats] = wb_addr;
        nbeats++;
      end
      prev = wb_stb;
      if (imem_resp) begin
        resp_cycle = c;
        data       = imem_rdata;
        err        = imem_err;
        break;
      end
    end
    imem_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({wb_cyc, wb_stb, imem_resp, imem_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl: got cyc/stb/resp/err=%b want 0000", {wb_cyc, wb_stb, imem_resp, imem_err});
    end
    n_vec++;
    if (wb_addr !== 32'h0 || imem_rdata !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h rdata=%h want 0", wb_addr, imem_rdata);
    end
    n_vec++;
    if (wb_we !== 1'b0 || wb_sel !== 4'hF) begin
      n_err++;
      $display("FAIL ties: got we=%b sel=%h want 0/F", wb_we, wb_sel);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic        exp_cyc, exp_stb;
    logic [31:0] exp_addr;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      exp_cyc  = (c <= 7);
      exp_stb  = (c <= 7) && (c % 2 == 1);
      exp_addr = 32'h100 + 32'(4 * ((c - 1) / 2));
      n_vec++;
      if (wb_cyc !== exp_cyc) begin
        n_err++;
        $display("FAIL basic_cyc c%0d: got %b want %b", c, wb_cyc, exp_cyc);
      end
      n_vec++;
      if (wb_stb !== exp_stb) begin
        n_err++;
        $display("FAIL basic_stb c%0d: got %b want %b", c, wb_stb, exp_stb);
      end
      if (exp_stb) begin
        n_vec++;
        if (wb_addr !== exp_addr) begin
          n_err++;
          $display("FAIL basic_addr c%0d: got %h want %h", c, wb_addr, exp_addr);
        end
      end
      n_vec++;
      if (imem_resp !== (c == 9)) begin
        n_err++;
        $display("FAIL basic_resp c%0d: got %b want %b", c, imem_resp, (c == 9));
      end
    end
    n_vec++;
    if (imem_rdata !== 128'hA000010C_A0000108_A0000104_A0000100) begin
      n_err++;
      $display("FAIL basic_rdata: got %h want A000010CA0000108A0000104A0000100", imem_rdata);
    end
    n_vec++;
    if (imem_err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_err: got %b want 0", imem_err);
    end
    imem_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (imem_resp !== 1'b0 || wb_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL basic_after: got resp=%b cyc=%b want 0/0", imem_resp, wb_cyc);
    end
    n_vec++;
    if (imem_rdata !== 128'hA000010C_A0000108_A0000104_A0000100) begin
      n_err++;
      $display("FAIL basic_hold: got %h want A000010CA0000108A0000104A0000100", imem_rdata);
    end
  endtask

  task automatic test_unaligned_wrap;
    logic [31:0]      req_a  [2];
    logic [3:0][31:0] exp_a  [2];
    logic [127:0]     exp_d  [2];
    logic [3:0][31:0] addrs;
    logic [127:0]     data;
    logic             err;
    int               nb, rc;
    req_a[0] = 32'h0000_0103;
    exp_a[0] = {32'h10C, 32'h108, 32'h104, 32'h100};
    exp_d[0] = 128'hA000010C_A0000108_A0000104_A0000100;
    req_a[1] = 32'hFFFF_FFF9;
    exp_a[1] = {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    exp_d[1] = 128'hA0000004_A0000000_9FFFFFFC_9FFFFFF8;
    for (int i = 0; i < 2; i++) begin
      run_fetch(req_a[i], addrs, nb, data, err, rc);
      n_vec++;
      if (nb !== 4) begin
        n_err++;
        $display("FAIL wrap%0d_beats: got %0d want 4", i, nb);
      end
      for (int j = 0; j < 4; j++) begin
        n_vec++;
        if (addrs[j] !== exp_a[i][j]) begin
          n_err++;
          $display("FAIL wrap%0d_addr%0d: got %h want %h", i, j, addrs[j], exp_a[i][j]);
        end
      end
      n_vec++;
      if (rc !== 9 || data !== exp_d[i] || err !== 1'b0) begin
        n_err++;
        $display("FAIL wrap%0d_resp: got cyc=%0d data=%h err=%b want 9 %h 0", i, rc, data, err, exp_d[i]);
      end
    end
  endtask

  task automatic test_wait_states;
    int           held, rc;
    logic [127:0] data;
    wait_addr = 32'h108;
    wait_n    = 3;
    held      = 0;
    rc        = -1;
    data      = '0;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (wb_stb && wb_addr == 32'h108) held++;
      if (imem_resp) begin
        rc   = c;
        data = imem_rdata;
        break;
      end
    end
    imem_req = 1'b0;
    wait_n   = 0;
    n_vec++;
    if (held !== 4) begin
      n_err++;
      $display("FAIL wait_held: got %0d want 4", held);
    end
    n_vec++;
    if (rc !== 12) begin
      n_err++;
      $display("FAIL wait_resp_cycle: got %0d want 12", rc);
    end
    n_vec++;
    if (data !== 128'hA000010C_A0000108_A0000104_A0000100) begin
      n_err++;
      $display("FAIL wait_rdata: got %h want A000010CA0000108A0000104A0000100", data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int               stb_cnt, rc, nresp, nb;
    logic             cyc9, err;
    logic [127:0]     data;
    logic [3:0][31:0] addrs;
    no_ack  = 1'b1;
    stb_cnt = 0;
    rc      = -1;
    nresp   = 0;
    cyc9    = 1'bx;
    err     = 1'b0;
    data    = '1;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (wb_stb && wb_addr == 32'h100) stb_cnt++;
      if (c == 9) cyc9 = wb_cyc;
      if (imem_resp) begin
        nresp++;
        if (rc < 0) begin
          rc   = c;
          err  = imem_err;
          data = imem_rdata;
        end
        imem_req = 1'b0;
      end
    end
    imem_req = 1'b0;
    no_ack   = 1'b0;
    n_vec++;
    if (stb_cnt !== 8) begin
      n_err++;
      $display("FAIL tmo_stb_cycles: got %0d want 8", stb_cnt);
    end
    n_vec++;
    if (cyc9 !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_cyc_drop: got %b want 0", cyc9);
    end
    n_vec++;
    if (rc !== 10 || nresp !== 1) begin
      n_err++;
      $display("FAIL tmo_resp: got cycle=%0d count=%0d want 10/1", rc, nresp);
    end
    n_vec++;
    if (err !== 1'b1 || data !== 128'h0) begin
      n_err++;
      $display("FAIL tmo_err_data: got err=%b data=%h want 1/0", err, data);
    end
    run_fetch(32'h100, addrs, nb, data, err, rc);
    n_vec++;
    if (rc !== 9 || err !== 1'b0 || data !== 128'hA000010C_A0000108_A0000104_A0000100) begin
      n_err++;
      $display("FAIL tmo_recover: got cyc=%0d err=%b data=%h want 9 0 A000010CA0000108A0000104A0000100", rc, err, data);
    end
  endtask

  task automatic test_abort;
    int               nresp, nb, rc;
    logic [3:0][31:0] addrs;
    logic [127:0]     data;
    logic             err;
    wait_addr = 32'h104;
    wait_n    = 2;
    nresp     = 0;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (imem_resp) nresp++;
      if (c == 3) begin
        n_vec++;
        if (wb_stb !== 1'b1 || wb_addr !== 32'h104) begin
          n_err++;
          $display("FAIL abort_beat1: got stb=%b addr=%h want 1/104", wb_stb, wb_addr);
        end
        imem_req = 1'b0;
      end
      if (c == 5) begin
        n_vec++;
        if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_addr !== 32'h104) begin
          n_err++;
          $display("FAIL abort_hold: got cyc=%b stb=%b addr=%h want 1/1/104", wb_cyc, wb_stb, wb_addr);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
          n_err++;
          $display("FAIL abort_drop: got cyc=%b stb=%b want 0/0", wb_cyc, wb_stb);
        end
      end
    end
    wait_n = 0;
    n_vec++;
    if (nresp !== 0) begin
      n_err++;
      $display("FAIL abort_noresp: got %0d resp pulses want 0", nresp);
    end
    run_fetch(32'h200, addrs, nb, data, err, rc);
    n_vec++;
    if (nb !== 4 || addrs !== {32'h20C, 32'h208, 32'h204, 32'h200}) begin
      n_err++;
      $display("FAIL abort_next_addrs: got n=%0d %h want 4 0000020c000002080000020400000200", nb, addrs);
    end
    n_vec++;
    if (rc !== 9 || data !== 128'hA000020C_A0000208_A0000204_A0000200) begin
      n_err++;
      $display("FAIL abort_next_resp: got cyc=%0d data=%h want 9 A000020CA0000208A0000204A0000200", rc, data);
    end
  endtask

  task automatic test_back_to_back;
    int nresp;
    nresp = 0;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 2) imem_addr = 32'h300;
      if (c == 7) begin
        n_vec++;
        if (wb_stb !== 1'b1 || wb_addr !== 32'h10C) begin
          n_err++;
          $display("FAIL b2b_last_beat: got stb=%b addr=%h want 1/10C", wb_stb, wb_addr);
        end
      end
      if (c == 9) begin
        n_vec++;
        if (imem_resp !== 1'b1 || imem_rdata !== 128'hA000010C_A0000108_A0000104_A0000100) begin
          n_err++;
          $display("FAIL b2b_first_resp: got resp=%b data=%h want 1 A000010CA0000108A0000104A0000100", imem_resp, imem_rdata);
        end
      end
      if (c == 10) begin
        n_vec++;
        if (wb_stb !== 1'b1 || wb_addr !== 32'h300) begin
          n_err++;
          $display("FAIL b2b_second_start: got stb=%b addr=%h want 1/300", wb_stb, wb_addr);
        end
        imem_req = 1'b0;
      end
      if (c > 10 && imem_resp) nresp++;
    end
    n_vec++;
    if (nresp !== 0 || wb_cyc !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_abort_second: got resp=%0d cyc=%b want 0/0", nresp, wb_cyc);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0][31:0] addrs;
    logic [127:0]     data;
    logic             err;
    int               nb, rc;
    @(negedge clk);
    imem_req  = 1'b1;
    imem_addr = 32'h100;
    repeat (5) @(negedge clk);
    n_vec++;
    if (wb_stb !== 1'b1 || wb_addr !== 32'h108) begin
      n_err++;
      $display("FAIL areset_pre: got stb=%b addr=%h want 1/108", wb_stb, wb_addr);
    end
    #2;
    rst      = 1'b1;
    imem_req = 1'b0;
    #1;
    n_vec++;
    if ({wb_cyc, wb_stb, imem_resp, imem_err} !== 4'b0000 || wb_addr !== 32'h0) begin
      n_err++;
      $display("FAIL areset_ctl: got cyc/stb/resp/err=%b addr=%h want 0000/0", {wb_cyc, wb_stb, imem_resp, imem_err}, wb_addr);
    end
    n_vec++;
    if (imem_rdata !== 128'h0) begin
      n_err++;
      $display("FAIL areset_rdata: got %h want 0", imem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    run_fetch(32'h40, addrs, nb, data, err, rc);
    n_vec++;
    if (nb !== 4 || addrs !== {32'h4C, 32'h48, 32'h44, 32'h40}) begin
      n_err++;
      $display("FAIL areset_next_addrs: got n=%0d %h want 4 0000004c000000480000004400000040", nb, addrs);
    end
    n_vec++;
    if (rc !== 9 || err !== 1'b0 || data !== 128'hA000004C_A0000048_A0000044_A0000040) begin
      n_err++;
      $display("FAIL areset_next_resp: got cyc=%0d err=%b data=%h want 9 0 A000004CA0000048A0000044A0000040", rc, err, data);
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    imem_req   = 1'b0;
    imem_addr  = '0;
    wb_ack     = 1'b0;
    wb_data_in = '0;
    no_ack     = 1'b0;
    wait_addr  = 32'hFFFF_FFFF;
    wait_n     = 0;
    wcnt       = 0;
    test_reset();
    test_basic();
    test_unaligned_wrap();
    test_wait_states();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
